// File: rtl/game_scene_renderer.sv
// Table-driven outlined-rectangle renderer for the 96x64 RGB565 OLED.
// Double-buffered rectangle table, commit on frame boundary, 2-cycle pixel pipeline.

module game_scene_renderer_lane #(
  parameter int XW        = 7,
  parameter int YW        = 6,
  parameter int OUTLINE_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [15:0]   fill,
  input  logic [15:0]   edge_col,
  input  logic          en,
  input  logic          blink,
  input  logic          blink_phase,
  output logic          hit_q,
  output logic [15:0]   col_q
);
  localparam logic [XW-1:0] OW_X = XW'(OUTLINE_W);
  localparam logic [YW-1:0] OW_Y = YW'(OUTLINE_W);

  logic          live, hit, on_edge;
  logic [XW-1:0] dx0, dx1;
  logic [YW-1:0] dy0, dy1;

  assign live = en && (x0 <= x1) && (y0 <= y1) && !(blink && blink_phase);
  assign hit  = live && (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);

  // Only consulted when hit is set, so the subtractions cannot wrap.
  assign dx0 = x - x0;
  assign dx1 = x1 - x;
  assign dy0 = y - y0;
  assign dy1 = y1 - y;
  assign on_edge = (dx0 < OW_X) || (dx1 < OW_X) || (dy0 < OW_Y) || (dy1 < OW_Y);

  // Colour is latched with the hit so a table swap cannot tear an in-flight pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      col_q <= '0;
    end else if (ld) begin
      hit_q <= hit;
      col_q <= on_edge ? edge_col : fill;
    end
  end
endmodule

module game_scene_renderer #(
  parameter int          XW          = 7,
  parameter int          YW          = 6,
  parameter int          WIDTH       = 96,
  parameter int          HEIGHT      = 64,
  parameter int          NUM_RECTS   = 8,
  parameter int          OUTLINE_W   = 2,
  parameter logic [15:0] BG_COLOR    = 16'hFFFF,
  parameter int          BLINK_SHIFT = 4,
  localparam int         IW          = $clog2(NUM_RECTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_begin,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_idx,
  input  logic [XW-1:0] wr_x0,
  input  logic [XW-1:0] wr_x1,
  input  logic [YW-1:0] wr_y0,
  input  logic [YW-1:0] wr_y1,
  input  logic [15:0]   wr_fill,
  input  logic [15:0]   wr_edge,
  input  logic          wr_en,
  input  logic          wr_blink,
  input  logic          commit,
  output logic          commit_pending,
  input  logic          pix_valid,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [15:0]   oled_data,
  output logic          pix_out_valid
);
  localparam int          STAGES  = 2;
  localparam logic [XW:0] W_LIM   = (XW+1)'(WIDTH);
  localparam logic [YW:0] H_LIM   = (YW+1)'(HEIGHT);
  localparam logic [IW:0] IDX_LIM = (IW+1)'(NUM_RECTS);

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [15:0]   fill;
    logic [15:0]   edge_col;
    logic          en;
    logic          blink;
  } rect_t;

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t                          state;
  rect_t [NUM_RECTS-1:0]           shadow, active, shadow_nxt;
  rect_t                           wr_ent;
  logic  [BLINK_SHIFT-1:0]         frm_cnt;
  logic                            blink_phase;
  logic  [STAGES:0]                vld_pipe;
  logic                            onscr_q;
  logic  [NUM_RECTS-1:0]           hit_q;
  logic  [NUM_RECTS-1:0][15:0]     col_q;
  logic  [15:0]                    sel;

  assign wr_ent      = {wr_x0, wr_x1, wr_y0, wr_y1, wr_fill, wr_edge, wr_en, wr_blink};
  assign blink_phase = frm_cnt[BLINK_SHIFT-1];

  // Shadow with this cycle's write merged in, so a same-cycle commit+copy sees it.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_valid && wr_ready && ({1'b0, wr_idx} < IDX_LIM))
      shadow_nxt[wr_idx] = wr_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_ready       <= 1'b1;
      commit_pending <= 1'b0;
      shadow         <= '0;
      active         <= '0;
      frm_cnt        <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (frame_begin) frm_cnt <= frm_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (commit && frame_begin) begin
            active <= shadow_nxt;
          end else if (commit) begin
            state          <= S_PEND;
            wr_ready       <= 1'b0;
            commit_pending <= 1'b1;
          end
        end
        S_PEND: begin
          if (frame_begin) begin
            active         <= shadow_nxt;
            state          <= S_IDLE;
            wr_ready       <= 1'b1;
            commit_pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: per-entry hit and colour, screen bounds.
  for (genvar i = 0; i < NUM_RECTS; i++) begin : gen_lane
    game_scene_renderer_lane #(.XW(XW), .YW(YW), .OUTLINE_W(OUTLINE_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld         (pix_valid),
      .x          (x),
      .y          (y),
      .x0         (active[i].x0),
      .x1         (active[i].x1),
      .y0         (active[i].y0),
      .y1         (active[i].y1),
      .fill       (active[i].fill),
      .edge_col   (active[i].edge_col),
      .en         (active[i].en),
      .blink      (active[i].blink),
      .blink_phase(blink_phase),
      .hit_q      (hit_q[i]),
      .col_q      (col_q[i])
    );
  end

  assign vld_pipe[0] = pix_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      onscr_q            <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (pix_valid) onscr_q <= ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    end
  end

  // Stage 2: ascending scan so the highest live index wins.
  always_comb begin
    sel = BG_COLOR;
    if (onscr_q)
      for (int i = 0; i < NUM_RECTS; i++)
        if (hit_q[i]) sel = col_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) oled_data <= '0;
    else if (vld_pipe[1]) oled_data <= sel;
  end

  assign pix_out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_game_scene_renderer.sv
// Scoreboard bench for game_scene_renderer: directed test-plan sequences
// followed by randomized traffic, checked against a rectangle-list model.

module tb_game_scene_renderer;
  logic        clk, rst_n, frame_begin, wr_valid, wr_ready, commit, commit_pending;
  logic        pix_valid, pix_out_valid, wr_en, wr_blink;
  logic [2:0]  wr_idx;
  logic [6:0]  wr_x0, wr_x1, x;
  logic [5:0]  wr_y0, wr_y1, y;
  logic [15:0] wr_fill, wr_edge, oled_data;

  game_scene_renderer dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1),
    .wr_fill(wr_fill), .wr_edge(wr_edge), .wr_en(wr_en), .wr_blink(wr_blink),
    .commit(commit), .commit_pending(commit_pending),
    .pix_valid(pix_valid), .x(x), .y(y),
    .oled_data(oled_data), .pix_out_valid(pix_out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int x0, x1, y0, y1;
    int fill, edg;
    bit en, blink;
  } rect_t;

  typedef struct {
    int          stamp;
    logic [15:0] col;
  } exp_t;

  rect_t sh[8], ac[8];
  bit    pend;
  int    fcnt;
  exp_t  sbq[$];
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0;
  logic [15:0] last_col;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the rectangle list, later entries overwrite earlier ones.
  function automatic logic [15:0] model_pix(int px, int py);
    logic [15:0] c;
    int d;
    rect_t r;
    if (px >= 96 || py >= 64) return 16'hFFFF;
    c = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      r = ac[i];
      if (!r.en || r.x0 > r.x1 || r.y0 > r.y1) continue;
      if (r.blink && fcnt >= 8) continue;
      if (px < r.x0 || px > r.x1 || py < r.y0 || py > r.y1) continue;
      d = px - r.x0;
      if (r.x1 - px < d) d = r.x1 - px;
      if (py - r.y0 < d) d = py - r.y0;
      if (r.y1 - py < d) d = r.y1 - py;
      c = (d < 2) ? r.edg[15:0] : r.fill[15:0];
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      sh[i] = '{0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
      ac[i] = sh[i];
    end
    pend = 0;
    fcnt = 0;
  endtask

  // One clock: check handshake outputs, queue pixel expectation, advance the model.
  task automatic tick();
    check("wr_ready", {31'd0, wr_ready}, {31'd0, !pend});
    check("commit_pending", {31'd0, commit_pending}, {31'd0, pend});
    if (rst_n && pix_valid) sbq.push_back('{cyc, model_pix(int'(x), int'(y))});
    if (!rst_n) model_reset();
    else begin
      if (wr_valid && !pend) begin
        sh[wr_idx].x0 = int'(wr_x0);   sh[wr_idx].x1 = int'(wr_x1);
        sh[wr_idx].y0 = int'(wr_y0);   sh[wr_idx].y1 = int'(wr_y1);
        sh[wr_idx].fill = int'(wr_fill); sh[wr_idx].edg = int'(wr_edge);
        sh[wr_idx].en = wr_en;         sh[wr_idx].blink = wr_blink;
      end
      if (!pend) begin
        if (commit && frame_begin) ac = sh;
        else if (commit) pend = 1;
      end else if (frame_begin) begin
        ac = sh;
        pend = 0;
      end
      if (frame_begin) fcnt = (fcnt + 1) % 16;
    end
    @(negedge clk);
    frame_begin = 0; wr_valid = 0; commit = 0; pix_valid = 0;
  endtask

  task automatic wr(int idx, int x0, int x1, int y0, int y1, int fill, int edg, bit en, bit blink);
    wr_valid = 1; wr_idx = 3'(idx);
    wr_x0 = 7'(x0); wr_x1 = 7'(x1); wr_y0 = 6'(y0); wr_y1 = 6'(y1);
    wr_fill = 16'(fill); wr_edge = 16'(edg); wr_en = en; wr_blink = blink;
  endtask

  task automatic px(int px_, int py_);
    pix_valid = 1; x = 7'(px_); y = 6'(py_);
  endtask

  task automatic do_reset();
    repeat (3) tick();
    rst_n = 0;
    tick();
    check("rst_oled_data", {16'd0, oled_data}, 32'd0);
    check("rst_pix_out_valid", {31'd0, pix_out_valid}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_commit_pending", {31'd0, commit_pending}, 32'd0);
    tick();
    rst_n = 1;
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    exp_t e;
    last_col = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) last_col = '0;
      else if (pix_out_valid) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pixel: got %h with no pixel outstanding (cycle %0d)", oled_data, cyc);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc, e.stamp + 2);
          check("pixel", {16'd0, oled_data}, {16'd0, e.col});
          last_col = e.col;
        end
      end else begin
        check("hold", {16'd0, oled_data}, {16'd0, last_col});
        if (sbq.size() > 0 && sbq[0].stamp + 2 <= cyc) begin
          n_chk++; n_fail++;
          $display("FAIL missing_pixel: got no output expected %h (cycle %0d)", sbq[0].col, cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int x0, x1, y0, y1;
    rst_n = 0; frame_begin = 0; wr_valid = 0; commit = 0; pix_valid = 0;
    wr_idx = 0; wr_x0 = 0; wr_x1 = 0; wr_y0 = 0; wr_y1 = 0;
    wr_fill = 0; wr_edge = 0; wr_en = 0; wr_blink = 0; x = 0; y = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    px(10, 10); tick(); tick(); tick();

    // Basic rectangle, visible only after the committing frame_begin.
    wr(0, 35, 62, 11, 22, 'h8204, 'h0000, 1, 0); tick();
    commit = 1; tick();
    px(40, 15); tick();
    frame_begin = 1; px(40, 15); tick();
    px(40, 15); tick();
    px(35, 15); tick();
    px(63, 15); tick();

    // Overlap, then disable the top entry.
    wr(3, 40, 50, 13, 20, 'hF800, 'h07E0, 1, 0); commit = 1; frame_begin = 1; px(45, 16); tick();
    px(45, 16); tick();
    wr(3, 40, 50, 13, 20, 'hF800, 'h07E0, 0, 0); commit = 1; tick();
    frame_begin = 1; tick();
    px(45, 16); tick();

    // Handshake: writes stalled and second commit ignored while pending.
    commit = 1; tick();
    repeat (3) begin
      wr(5, 0, 95, 0, 63, 'h001F, 'h07E0, 1, 0); commit = 1; px(45, 16); tick();
    end
    frame_begin = 1; wr(5, 0, 95, 0, 63, 'h001F, 'h07E0, 1, 0); tick();
    wr(5, 0, 95, 0, 63, 'h001F, 'h07E0, 1, 0); px(0, 0); tick();
    commit = 1; frame_begin = 1; px(0, 0); tick();
    px(0, 0); tick();
    px(45, 16); tick();
    wr(5, 0, 95, 0, 63, 'h001F, 'h07E0, 0, 0); commit = 1; frame_begin = 1; tick();

    // Blink across more than one counter wrap.
    wr(0, 35, 62, 11, 22, 'h8204, 'h0000, 1, 1); commit = 1; frame_begin = 1; tick();
    repeat (36) begin
      frame_begin = 1; px(40, 15); tick();
      px(40, 15); tick();
    end

    // Degenerate entry and off-screen coordinate.
    wr(1, 50, 40, 5, 30, 'h1234, 'h4321, 1, 0); commit = 1; frame_begin = 1; tick();
    px(45, 10); tick();
    px(100, 5); tick();

    // Reset while pending drops the commit and empties the tables.
    wr(6, 0, 95, 0, 63, 'h0AAA, 'h0555, 1, 0); commit = 1; frame_begin = 1; tick();
    commit = 1; tick();
    do_reset();
    px(40, 15); tick();
    px(10, 10); tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      frame_begin = ($urandom_range(0, 9) == 0);
      commit      = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) == 0) begin
        x0 = $urandom_range(0, 100);
        x1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, x0) : x0 + $urandom_range(0, 30);
        if (x1 > 127) x1 = 127;
        y0 = $urandom_range(0, 60);
        y1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, y0) : y0 + $urandom_range(0, 20);
        if (y1 > 63) y1 = 63;
        wr($urandom_range(0, 7), x0, x1, y0, y1, $urandom_range(0, 65535),
           $urandom_range(0, 65535), $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 4) != 0) px($urandom_range(0, 110), $urandom_range(0, 63));
      tick();
    end

    repeat (4) tick();
    check("queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
